// File: rtl/led_ctrl_pkg.sv
// Shared constants and types for the LED arbiter.
package led_ctrl_pkg;

  localparam int LED_W           = 16;
  localparam int DEF_HOLD_CYCLES = 50_000_000;
  localparam int DEF_HB_WIDTH    = 27;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_arbiter_if.sv
// Bundle between the status producers and the LED arbiter.
interface led_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]                     req;
  logic [NUM_REQ*led_ctrl_pkg::LED_W-1:0] req_pattern;
  logic [NUM_REQ-1:0]                     grant;
  logic [led_ctrl_pkg::LED_W-1:0]         led;
  logic                                   busy;

  // Producer side: raises requests, watches the grant.
  modport master (
    output req, req_pattern,
    input  grant, led, busy
  );

  // Arbiter side.
  modport slave (
    input  req, req_pattern,
    output grant, led, busy
  );

endinterface

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above start,
// wrapping modulo NUM_REQ (valid for non-power-of-two counts).
module led_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   start,
  output logic               valid,
  output logic [PTR_W-1:0]   winner
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, start} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
        sum = sum - (PTR_W + 1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of the 16-LED bank with a minimum display time per owner.
// Optional idle heartbeat on led[0] when LED_ARB_HEARTBEAT_EN is defined.
module led_arbiter
  import led_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int HB_WIDTH    = DEF_HB_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  led_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  // Low for the first edge after reset release so no grant lands on it.
  logic               arm_q;

  logic [LED_W-1:0]   pat [NUM_REQ];
  logic [LED_W-1:0]   idle_led;
  logic [NUM_REQ-1:0] pick_req;
  logic [PTR_W-1:0]   pick_start;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_winner;

  function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Unflatten the pattern bus into one word per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pat
    assign pat[gi] = bus.req_pattern[gi*LED_W +: LED_W];
  end

`ifdef LED_ARB_HEARTBEAT_EN
  logic [HB_WIDTH-1:0] hb_q;

  // Free-running heartbeat counter, independent of arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hb_q <= '0;
    else        hb_q <= hb_q + 1'b1;
  end

  assign idle_led = {{(LED_W-1){1'b0}}, hb_q[HB_WIDTH-1]};
`else
  assign idle_led = '0;
`endif

  // One picker serves both cases: from the pointer in IDLE, and from the
  // slot after the current owner (owner excluded) at expiry.
  assign pick_start = (state_q == IDLE) ? ptr_q : inc_wrap(owner_q);
  assign pick_req   = (state_q == IDLE) ? bus.req : (bus.req & ~grant_q);

  led_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (pick_req),
    .start  (pick_start),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Next-state logic for ownership, hold timer and displayed pattern.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    led_d   = led_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        led_d = idle_led;
        if (arm_q && pick_valid) begin
          state_d = OWN;
          owner_d = pick_winner;
          grant_d = NUM_REQ'(1) << pick_winner;
          hold_d  = '0;
          led_d   = pat[pick_winner];
          busy_d  = 1'b1;
        end
      end
      OWN: begin
        if (hold_q != CNT_MAX) begin
          hold_d = hold_q + 1'b1;
          if (bus.req[owner_q]) led_d = pat[owner_q];
        end else if (pick_valid) begin
          owner_d = pick_winner;
          grant_d = NUM_REQ'(1) << pick_winner;
          hold_d  = '0;
          led_d   = pat[pick_winner];
          ptr_d   = inc_wrap(pick_winner);
        end else if (bus.req[owner_q]) begin
          // Sole requester keeps the LEDs with the timer parked at expiry.
          led_d = pat[owner_q];
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = inc_wrap(owner_q);
          led_d   = idle_led;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        led_d   = '0;
      end
    endcase
  end

  // State registers; reset clears outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      arm_q   <= 1'b1;
    end
  end

  assign bus.grant = grant_q;
  assign bus.led   = led_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter (NUM_REQ=4, HOLD_CYCLES=4, HB_WIDTH=4).
module tb_led_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam int HBW  = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  // Reference model: owner index (-1 idle), cycles owned, search pointer.
  int          m_owner;
  int          m_cnt;
  int          m_ptr;
  logic [15:0] m_led;
  bit          m_arm;
  int          m_hb;

  led_arbiter_if #(.NUM_REQ(N)) bus ();

  led_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .HB_WIDTH(HBW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] idle_val();
`ifdef LED_ARB_HEARTBEAT_EN
    return (((m_hb >> (HBW - 1)) & 1) != 0) ? 16'h0001 : 16'h0000;
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [3:0] m_grant();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_led = 16'h0; m_arm = 0; m_hb = 0;
  endtask

  task automatic set_pat(input int i, input logic [15:0] v);
    bus.req_pattern[i*16 +: 16] = v;
  endtask

  // Advance one clock and step the reference model with the pre-edge inputs.
  task automatic tick();
    logic [3:0]  r;
    logic [63:0] p;
    int          w;
    bit          found;
    r = bus.req;
    p = bus.req_pattern;
    w = 0;
    @(posedge clk);
    if (m_owner < 0) begin
      found = 0;
      if (m_arm)
        for (int k = 0; k < N; k++)
          if (!found && r[(m_ptr + k) % N]) begin found = 1; w = (m_ptr + k) % N; end
      if (found) begin m_owner = w; m_cnt = 0; m_led = p[w*16 +: 16]; end
      else m_led = idle_val();
    end else if (m_cnt < HOLD - 1) begin
      m_cnt++;
      if (r[m_owner]) m_led = p[m_owner*16 +: 16];
    end else begin
      found = 0;
      for (int k = 1; k < N; k++)
        if (!found && r[(m_owner + k) % N]) begin found = 1; w = (m_owner + k) % N; end
      if (found) begin
        m_owner = w; m_cnt = 0; m_ptr = (w + 1) % N; m_led = p[w*16 +: 16];
      end else if (r[m_owner]) begin
        m_led = p[m_owner*16 +: 16];
      end else begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_led = idle_val();
      end
    end
    m_arm = 1;
    m_hb  = (m_hb + 1) % (1 << HBW);
    #1;
    $display("t=%0t req=%b grant=%b led=%h busy=%b", $time, r, bus.grant, bus.led, bus.busy);
  endtask

  // Reset pulse between edges; leaves the arbiter idle and unarmed.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.req = 4'b0010;
    set_pat(1, 16'h1234);
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0000) begin
      n_err++; $display("FAIL reset_first_edge grant=%b want=0000", bus.grant);
    end
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0010 || bus.led !== 16'h1234) begin
      n_err++; $display("FAIL reset_grant grant=%b led=%h want 0010/1234", bus.grant, bus.led);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.grant !== 4'b0000 || bus.led !== 16'h0000 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_async grant=%b led=%h busy=%b want 0/0/0", bus.grant, bus.led, bus.busy);
    end
    rst_n = 1'b1;
    model_reset();
    bus.req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (bus.grant !== 4'b0000 || bus.led !== m_led || bus.busy !== 1'b0) begin
        n_err++; $display("FAIL reset_idle grant=%b led=%h busy=%b want 0000/%h/0", bus.grant, bus.led, bus.busy, m_led);
      end
    end
  endtask

  task automatic test_single_drop();
    do_reset();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0001;
    set_pat(0, 16'hA5A5);
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0001 || bus.led !== 16'hA5A5 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL single_grant grant=%b led=%h busy=%b want 0001/a5a5/1", bus.grant, bus.led, bus.busy);
    end
    tick();
    bus.req = 4'b0000;
    set_pat(0, 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (bus.grant !== 4'b0001 || bus.led !== 16'hA5A5) begin
        n_err++; $display("FAIL single_hold grant=%b led=%h want 0001/a5a5", bus.grant, bus.led);
      end
    end
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.led !== m_led) begin
      n_err++; $display("FAIL single_release grant=%b busy=%b led=%h want 0000/0/%h", bus.grant, bus.busy, bus.led, m_led);
    end
  endtask

  task automatic test_rotation();
    logic [15:0] pv [N];
    int          o;
    do_reset();
    bus.req = 4'b0000;
    tick();
    for (int i = 0; i < N; i++) begin pv[i] = 16'($urandom); set_pat(i, pv[i]); end
    bus.req = 4'b1111;
    for (int t = 1; t <= 17; t++) begin
      tick();
      o = ((t - 1) / HOLD) % N;
      n_cmp++;
      if (bus.grant !== 4'(1 << o) || bus.led !== pv[o]) begin
        n_err++; $display("FAIL rotation t=%0d grant=%b led=%h want %b/%h", t, bus.grant, bus.led, 4'(1 << o), pv[o]);
      end
    end
  endtask

  task automatic test_pattern_track();
    do_reset();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0100;
    set_pat(2, 16'h0001);
    tick();
    set_pat(2, 16'h8000);
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0100 || bus.led !== 16'h8000) begin
      n_err++; $display("FAIL pattern_track grant=%b led=%h want 0100/8000", bus.grant, bus.led);
    end
  endtask

  task automatic test_late_competitor();
    logic [15:0] p3;
    do_reset();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0001;
    set_pat(0, 16'h0F0F);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (bus.grant !== 4'b0001 || bus.led !== 16'h0F0F) begin
        n_err++; $display("FAIL late_solo i=%0d grant=%b led=%h want 0001/0f0f", i, bus.grant, bus.led);
      end
    end
    p3 = 16'($urandom);
    set_pat(3, p3);
    bus.req = 4'b1001;
    tick();
    n_cmp++;
    if (bus.grant !== 4'b1000 || bus.led !== p3) begin
      n_err++; $display("FAIL late_competitor grant=%b led=%h want 1000/%h", bus.grant, bus.led, p3);
    end
  endtask

  task automatic test_heartbeat();
    logic [15:0] exp_led;
    do_reset();
    bus.req = 4'b0000;
    for (int k = 1; k <= 40; k++) begin
      tick();
`ifdef LED_ARB_HEARTBEAT_EN
      exp_led = ((((k - 1) / 8) % 2) != 0) ? 16'h0001 : 16'h0000;
`else
      exp_led = 16'h0000;
`endif
      n_cmp++;
      if (bus.led !== exp_led) begin
        n_err++; $display("FAIL heartbeat k=%0d led=%h want %h", k, bus.led, exp_led);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    bus.req = 4'b0000;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < N; i++) bus.req[i] = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 2) == 0) set_pat($urandom_range(0, N - 1), 16'($urandom));
      tick();
      n_cmp++;
      if (bus.grant !== m_grant() || bus.led !== m_led || bus.busy !== (m_owner >= 0)) begin
        n_err++;
        $display("FAIL random t=%0d grant=%b led=%h busy=%b want %b/%h/%b",
                 t, bus.grant, bus.led, bus.busy, m_grant(), m_led, (m_owner >= 0));
      end
    end
  endtask

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    rst_n           = 1'b0;
    bus.req         = '0;
    bus.req_pattern = '0;
    model_reset();
    #12;
    rst_n = 1'b1;
    test_reset();
    test_single_drop();
    test_rotation();
    test_pattern_track();
    test_late_competitor();
    test_heartbeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
